// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (REQ issue, WAIT response, HOLD buffered)
//   NOP_INSTR     : canonical RISC-V NOP (addi x0,x0,0), IF/ID reset content
//   INSTR_W       : instruction / address width
//   pc_step       : sequential next-PC helper (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Sequential fetch address; natural 32-bit overflow gives the wrap.
  function automatic logic [INSTR_W-1:0] pc_step(input logic [INSTR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Priority: flush > load > stall(hold) > bubble.
// Reset content is an invalid NOP at PC 0.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   load              : capture d_pc/d_instr as a live instruction
//   stall             : hold current contents
//   flush             : invalidate contents (beats stall and load)
//   d_pc, d_instr     : incoming PC and instruction word
//   q_valid, q_pc, q_instr : registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               stall,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic               q_valid,
  output logic [INSTR_W-1:0] q_pc,
  output logic [INSTR_W-1:0] q_instr
);

  logic               valid_r;
  logic [INSTR_W-1:0] pc_r;
  logic [INSTR_W-1:0] instr_r;

  // IF/ID storage; pc/instr are only rewritten on load so a bubble keeps the
  // last word visible (valid low marks it dead).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      pc_r    <= 32'h0000_0000;
      instr_r <= NOP_INSTR;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= d_pc;
      instr_r <= d_instr;
    end else if (stall) begin
      valid_r <= valid_r;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign q_valid = valid_r;
  assign q_pc    = pc_r;
  assign q_instr = instr_r;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, issues word fetches over a
// request/response handshake (one outstanding), buffers a response that
// arrives while decode is stalled, and feeds the IF/ID register.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   imem_req/imem_addr    : fetch request (decoded from state / pc)
//   imem_ready            : request accepted when imem_req && imem_ready
//   imem_rvalid/imem_rdata: in-order response, sampled only in WAIT
//   stall, flush          : decode back-pressure / IF/ID kill
//   redirect_valid/_pc    : branch/jump target load
//   if_id_valid/_pc/_instruc : IF/ID pipeline register outputs
//   fetch_misaligned      : one-cycle pulse on a misaligned redirect
//                           (only when FETCH_ALIGN_CHECK_EN is defined)
// Build option: FETCH_ALIGN_CHECK_EN
//   defined   -> misaligned redirect is taken but fetching is suppressed until
//                the next redirect or reset, with a one-cycle flag pulse.
//   undefined -> redirect_pc[1:0] is forced to zero; no fetch_misaligned port.
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic [INSTR_W-1:0] if_id_instruc,
  output logic               fetch_misaligned
`else
  output logic [INSTR_W-1:0] if_id_instruc
`endif
);

  fetch_state_e       state_r;
  logic [INSTR_W-1:0] pc_r;
  logic [INSTR_W-1:0] pend_pc_r;
  logic [INSTR_W-1:0] hold_instr_r;
  logic               drop_r;

  logic [INSTR_W-1:0] redir_pc_s;
  logic               redir_bad_s;
  logic               suppress_s;
  logic               req_s;
  logic               accept_s;
  logic               kill_s;
  logic               if_id_free_s;
  logic               if_id_valid_s;
  logic               load_s;
  logic [INSTR_W-1:0] load_instr_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_r;
  logic suppress_r;

  assign redir_pc_s       = redirect_pc;
  assign redir_bad_s      = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign suppress_s       = suppress_r;
  assign fetch_misaligned = misalign_r;

  // Misalignment pulse and sticky fetch suppression; any redirect re-evaluates it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_r <= 1'b0;
      suppress_r <= 1'b0;
    end else begin
      misalign_r <= redir_bad_s;
      if (redirect_valid) begin
        suppress_r <= redir_bad_s;
      end
    end
  end
`else
  // Word-aligned target: low address bits are simply ignored.
  assign redir_pc_s  = redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad_s = 1'b0;
  assign suppress_s  = 1'b0;
`endif

  // Request is decoded from state so it drops as soon as reset asserts.
  assign req_s        = (state_r == REQ) && !reset && !suppress_s && !redir_bad_s_hold();
  assign accept_s     = req_s && imem_ready;
  assign kill_s       = flush || redirect_valid;
  assign if_id_free_s = !stall || !if_id_valid_s;

  assign imem_req  = req_s;
  assign imem_addr = pc_r;

  // Constant-false request gate term; suppression is fully registered above.
  function automatic logic redir_bad_s_hold();
    return 1'b0;
  endfunction

  // IF/ID load decision and data source (live response or hold buffer).
  always_comb begin
    load_s       = 1'b0;
    load_instr_s = imem_rdata;
    case (state_r)
      WAIT: begin
        if (imem_rvalid && !drop_r && !redirect_valid && if_id_free_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      HOLD: begin
        load_instr_s = hold_instr_r;
        if (!stall && !redirect_valid) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s       = 1'b0;
        load_instr_s = imem_rdata;
      end
    endcase
  end

  // Fetch FSM: PC update, outstanding-request tracking and hold buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= REQ;
      pc_r         <= RESET_PC;
      pend_pc_r    <= 32'h0000_0000;
      hold_instr_r <= NOP_INSTR;
      drop_r       <= 1'b0;
    end else begin
      // Redirect target overrides the sequential increment.
      if (redirect_valid) begin
        pc_r <= redir_pc_s;
      end else if (accept_s) begin
        pc_r <= pc_step(pc_r);
      end

      case (state_r)
        REQ: begin
          if (accept_s) begin
            pend_pc_r <= pc_r;
            // A redirect racing the accept makes the in-flight word stale.
            drop_r    <= redirect_valid;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_r <= 1'b0;
            if (drop_r || kill_s || if_id_free_s) begin
              // Discarded, or delivered straight into IF/ID via load_s.
              state_r <= REQ;
            end else begin
              hold_instr_r <= imem_rdata;
              state_r      <= HOLD;
            end
          end else if (redirect_valid) begin
            drop_r <= 1'b1;
          end
        end
        HOLD: begin
          // A kill discards the buffered word; otherwise it drains when unstalled.
          if (kill_s || !stall) begin
            state_r <= REQ;
          end
        end
        default: begin
          state_r <= REQ;
          drop_r  <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load_s),
    .stall   (stall),
    .flush   (kill_s),
    .d_pc    (pend_pc_r),
    .d_instr (load_instr_s),
    .q_valid (if_id_valid_s),
    .q_pc    (if_id_pc),
    .q_instr (if_id_instruc)
  );

  assign if_id_valid = if_id_valid_s;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed, table-driven bench for fetch_stage. Each table row gives one
// cycle of inputs, the expected request/address during that cycle and the
// expected IF/ID contents after the following rising edge. Hand-written
// sequences cover reset mid-fetch and redirect alignment handling.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A0  = 32'h0010_0093;
  localparam logic [31:0] A1  = 32'h0020_0113;
  localparam logic [31:0] A2  = 32'h0030_0193;
  localparam logic [31:0] B0  = 32'h0040_0213;
  localparam logic [31:0] B1  = 32'h0050_0293;
  localparam logic [31:0] C0  = 32'h0060_0313;
  localparam logic [31:0] C1  = 32'h0070_0393;
  localparam logic [31:0] E0  = 32'h0080_0413;
  localparam logic [31:0] E1  = 32'h0090_0493;
  localparam logic [31:0] D1  = 32'hDEAD_0001;
  localparam logic [31:0] D2  = 32'hDEAD_0002;
  localparam logic [31:0] D3  = 32'hDEAD_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        st;
    logic        fl;
    logic        rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .if_id_instruc  (if_id_instruc),
    .fetch_misaligned (fetch_misaligned)
`else
    .if_id_instruc  (if_id_instruc)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic st, input logic fl, input logic rd,
                              input logic [31:0] rpc, input logic e_req,
                              input logic [31:0] e_addr, input logic e_v,
                              input logic [31:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.st = st; v.fl = fl; v.rd = rd;
    v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
    v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata;
    stall = st; flush = fl; redirect_valid = rd; redirect_pc = rpc;
  endtask

  initial begin
    //             rdy rv rdata  st fl rd rpc       | req addr      v pc        ins
    // Straight-line fetch, one word every 2 cycles.
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h000,1'b0,32'h000,NOP));
    tbl.push_back(mk(1'b0,1'b1,A0,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h004,1'b1,32'h000,A0));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h004,1'b0,32'h000,A0));
    tbl.push_back(mk(1'b0,1'b1,A1,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h008,1'b1,32'h004,A1));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h008,1'b0,32'h004,A1));
    tbl.push_back(mk(1'b0,1'b1,A2,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h00C,1'b1,32'h008,A2));
    // Stall 4 cycles, response arrives mid-stall and waits in HOLD.
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h00C,1'b1,32'h008,A2));
    tbl.push_back(mk(1'b0,1'b1,B0,   1'b1,1'b0,1'b0,32'h0,  1'b0,32'h010,1'b1,32'h008,A2));
    tbl.push_back(mk(1'b0,1'b0,32'h0,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h010,1'b1,32'h008,A2));
    tbl.push_back(mk(1'b0,1'b0,32'h0,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h010,1'b1,32'h008,A2));
    tbl.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h010,1'b1,32'h00C,B0));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h010,1'b0,32'h00C,B0));
    tbl.push_back(mk(1'b0,1'b1,B1,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h014,1'b1,32'h010,B1));
    // Redirect to 0x100 while in WAIT: in-flight word dropped.
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h014,1'b0,32'h010,B1));
    tbl.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,32'h100,1'b0,32'h018,1'b0,32'h010,B1));
    tbl.push_back(mk(1'b0,1'b1,D1,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h100,1'b0,32'h010,B1));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h100,1'b0,32'h010,B1));
    tbl.push_back(mk(1'b0,1'b1,C0,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h104,1'b1,32'h100,C0));
    // Flush together with stall kills a live IF/ID entry.
    tbl.push_back(mk(1'b0,1'b0,32'h0,1'b1,1'b1,1'b0,32'h0,  1'b1,32'h104,1'b0,32'h100,C0));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h104,1'b0,32'h100,C0));
    tbl.push_back(mk(1'b0,1'b1,C1,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h108,1'b1,32'h104,C1));
    // Redirect in REQ with same-cycle accept, then redirect racing rvalid.
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b1,32'h200,1'b1,32'h108,1'b0,32'h104,C1));
    tbl.push_back(mk(1'b0,1'b1,D2,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h200,1'b0,32'h104,C1));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h200,1'b0,32'h104,C1));
    tbl.push_back(mk(1'b0,1'b1,D3,   1'b0,1'b0,1'b1,32'h300,1'b0,32'h204,1'b0,32'h104,C1));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h300,1'b0,32'h104,C1));
    // Word parked in HOLD, then discarded by a redirect.
    tbl.push_back(mk(1'b0,1'b1,E0,   1'b0,1'b0,1'b0,32'h0,  1'b0,32'h304,1'b1,32'h300,E0));
    tbl.push_back(mk(1'b1,1'b0,32'h0,1'b1,1'b0,1'b0,32'h0,  1'b1,32'h304,1'b1,32'h300,E0));
    tbl.push_back(mk(1'b0,1'b1,E1,   1'b1,1'b0,1'b0,32'h0,  1'b0,32'h308,1'b1,32'h300,E0));
    tbl.push_back(mk(1'b0,1'b0,32'h0,1'b1,1'b0,1'b1,32'h400,1'b0,32'h308,1'b0,32'h300,E0));
    tbl.push_back(mk(1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,  1'b1,32'h400,1'b0,32'h300,E0));

    // Reset state.
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req",   {31'h0, imem_req},    32'h0);
    chk("rst.valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst.pc",    if_id_pc,             32'h0);
    chk("rst.ins",   if_id_instruc,        NOP);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst.mis",   {31'h0, fetch_misaligned}, 32'h0);
`endif
    reset = 1'b0;
    #1;
    chk("rel.req",  {31'h0, imem_req}, 32'h1);
    chk("rel.addr", imem_addr,         32'h0);

    // Table-driven cycles.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].st, tbl[i].fl, tbl[i].rd, tbl[i].rpc);
      #1;
      chk($sformatf("v%0d.req", i),  {31'h0, imem_req}, {31'h0, tbl[i].e_req});
      chk($sformatf("v%0d.addr", i), imem_addr,         tbl[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid", i), {31'h0, if_id_valid}, {31'h0, tbl[i].e_v});
      chk($sformatf("v%0d.pc", i),    if_id_pc,             tbl[i].e_pc);
      chk($sformatf("v%0d.ins", i),   if_id_instruc,        tbl[i].e_ins);
    end

    // Reset while in WAIT, then a stale response in REQ.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rw.req",   {31'h0, imem_req},    32'h0);
    chk("rw.valid", {31'h0, if_id_valid}, 32'h0);
    chk("rw.ins",   if_id_instruc,        NOP);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw.req2",  {31'h0, imem_req}, 32'h1);
    chk("rw.addr2", imem_addr,         32'h0);
    @(posedge clk);
    #1;
    chk("rw.stale.valid", {31'h0, if_id_valid}, 32'h0);
    chk("rw.stale.ins",   if_id_instruc,        NOP);
    chk("rw.stale.addr",  imem_addr,            32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h00A0_0513, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("rw.first.valid", {31'h0, if_id_valid}, 32'h1);
    chk("rw.first.pc",    if_id_pc,             32'h0);
    chk("rw.first.ins",   if_id_instruc,        32'h00A0_0513);

    // Redirect to a non-word-aligned target (state REQ, pc 0x4).
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
    @(posedge clk);
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis.pulse", {31'h0, fetch_misaligned}, 32'h1);
    chk("mis.req",   {31'h0, imem_req},         32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mis.req2", {31'h0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    chk("mis.pulse2", {31'h0, fetch_misaligned}, 32'h0);
    chk("mis.req3",   {31'h0, imem_req},         32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
    @(posedge clk);
    #1;
    chk("mis.resume.req",  {31'h0, imem_req}, 32'h1);
    chk("mis.resume.addr", imem_addr,         32'h0000_0400);
    chk("mis.pulse3",      {31'h0, fetch_misaligned}, 32'h0);
`else
    chk("aln.req",  {31'h0, imem_req}, 32'h1);
    chk("aln.addr", imem_addr,         32'h0000_0100);
`endif
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
